debug_word_rx: RTL and testbench
================================

DEBUG_WORD_RX -- requirements
Module: debug_word_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the assembled word width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH_UART, default 8, giving the data bits per UART frame.
REQ-003 The block SHALL have parameter PARITY_WIDTH_UART, default 1, giving the width of the parity line.
REQ-004 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the i_clock cycles per UART bit.
REQ-005 The block SHALL have parameter TIMEOUT_BITS, default 32, giving the maximum idle gap, in bit times, between bytes of one word.
REQ-006 The block SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port i_rx_data, input, 1 bit: serial line driven by the debug unit's o_tx_data; idle high.
REQ-009 The block SHALL have port i_rx_parity, input, PARITY_WIDTH_UART bits: parity line driven by the debug unit's o_parity.
REQ-010 The block SHALL have port i_clear_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port o_word, output, DATA_WIDTH bits: last fully assembled word.
REQ-012 The block SHALL have port o_word_valid, output, 1 bit: single-cycle pulse marking a new o_word.
REQ-013 The block SHALL have port o_word_count, output, 16 bits: count of words received.
REQ-014 The block SHALL have port o_parity_err, output, 1 bit: sticky parity-error flag.
REQ-015 The block SHALL have port o_frame_err, output, 1 bit: sticky stop-bit error flag.
REQ-016 The block SHALL have port o_timeout, output, 1 bit: single-cycle pulse when a partial word is discarded on timeout.

Function
REQ-017 i_rx_data and i_rx_parity SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized values.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START on a synchronized falling edge of the line.
REQ-019 In START, the block SHALL sample at CLKS_PER_BIT/2 cycles.
- Line low: go to DATA.
- Line high: treat as a glitch, return to IDLE, no error.
REQ-020 In DATA, the block SHALL sample DATA_WIDTH_UART bits, each CLKS_PER_BIT cycles apart, at mid-bit, LSB first.
REQ-021 In STOP, at mid-bit, the block SHALL sample the line and the parity input together, then return to IDLE.
- Stop bit low: set o_frame_err and discard the byte.
- Parity input not equal to the even parity (XOR) of the 8 data bits: set o_parity_err and discard the byte.
REQ-022 Good bytes SHALL be packed little-endian: byte 0 goes to o_word[7:0], byte 3 to o_word[31:24]; a 2-bit byte index tracks the position.
REQ-023 On the 4th good byte, o_word SHALL update and o_word_valid SHALL pulse high for exactly 1 cycle.
- The pulse is in the cycle after the stop-bit sample (latency 1 clock).
- In the same cycle, o_word_count increments; it wraps 0xFFFF->0x0000.
- The byte index returns to 0.
REQ-024 o_word SHALL hold its value between valid pulses.
REQ-025 Any discarded byte (parity or frame error) SHALL also discard the partial word: the byte index resets to 0 and o_word is unchanged.
REQ-026 A gap counter SHALL run in IDLE while the byte index is non-zero.
- When it reaches TIMEOUT_BITS*CLKS_PER_BIT cycles: byte index resets to 0, o_timeout pulses for 1 cycle.
- It restarts on every start bit.
- It does not run while the byte index is 0.
REQ-027 o_parity_err and o_frame_err SHALL stay set until i_clear_err is high at a clock edge.
- If an error and i_clear_err occur in the same cycle, set wins.
REQ-028 A start edge detected in the same cycle that the timeout fires SHALL be accepted as byte 0 of a new word.

Reset
REQ-029 While i_reset is low, the block SHALL force the following, independent of the clock:
- FSM to IDLE; synchronizers to 1.
- byte index and all counters to 0.
- o_word = 0, o_word_valid = 0, o_word_count = 0, o_parity_err = 0, o_frame_err = 0, o_timeout = 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame and partial word; after release, the block waits in IDLE for a fresh falling edge.

Verification
REQ-031 The bench SHALL drive bytes 0x78, 0x56, 0x34, 0x12 with correct parity -> one o_word_valid pulse, o_word = 0x12345678, o_word_count = 1.
REQ-032 The bench SHALL drive byte 0x01 with parity line 0 -> o_parity_err = 1, no valid pulse; then 4 good bytes 0xEF, 0xBE, 0xAD, 0xDE -> o_word = 0xDEADBEEF; i_clear_err -> o_parity_err = 0.
REQ-033 The bench SHALL drive 2 good bytes, then idle for 33 bit times -> o_timeout pulses once; then 4 bytes 0xAA -> o_word = 0xAAAAAAAA.
REQ-034 The bench SHALL drive one frame with the stop bit low -> o_frame_err = 1, byte index 0, o_word unchanged.
REQ-035 The bench SHALL drive a 0.25-bit low glitch on an idle line -> no state change; then assert i_reset in the DATA state -> all outputs 0, and a following good word is received correctly.
REQ-036 The bench SHALL preload o_word_count to 0xFFFF via 65535 words (or force) and send one more word -> o_word_count = 0x0000.

Source files
------------

// File: rtl/debug_word_rx.sv
// Receives bytes from the debug unit's UART (data line plus a separate parity line)
// and packs them little-endian into words, with sticky error flags and an inter-byte timeout.
module debug_word_rx #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned DATA_WIDTH_UART   = 8,
  parameter int unsigned PARITY_WIDTH_UART = 1,
  parameter int unsigned CLKS_PER_BIT      = 16,
  parameter int unsigned TIMEOUT_BITS      = 32
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_rx_data,
  input  logic [PARITY_WIDTH_UART-1:0] i_rx_parity,
  input  logic                         i_clear_err,
  output logic [DATA_WIDTH-1:0]        o_word,
  output logic                         o_word_valid,
  output logic [15:0]                  o_word_count,
  output logic                         o_parity_err,
  output logic                         o_frame_err,
  output logic                         o_timeout
);

  localparam int unsigned BYTES     = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int unsigned IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W     = (DATA_WIDTH_UART > 1) ? $clog2(DATA_WIDTH_UART) : 1;
  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                       state_q, state_d;
  logic                         rx_meta_q, rx_sync_q, rx_prev_q;
  logic [PARITY_WIDTH_UART-1:0] par_meta_q, par_sync_q;
  logic [CNT_W-1:0]             clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH_UART-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]             byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]        asm_q, asm_d;
  logic [DATA_WIDTH-1:0]        word_q, word_d;
  logic                         valid_q, valid_d;
  logic [15:0]                  count_q, count_d;
  logic                         perr_q, perr_d;
  logic                         ferr_q, ferr_d;
  logic                         tmo_q, tmo_d;
  logic [GAP_W-1:0]             gap_q, gap_d;

  logic start_edge;
  logic stop_sample;
  logic frame_bad;
  logic parity_bad;
  logic byte_good;
  logic gap_fire;

  assign start_edge = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      par_meta_q <= '1;
      par_sync_q <= '1;
    end else begin
      rx_meta_q  <= i_rx_data;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      par_meta_q <= i_rx_parity;
      par_sync_q <= par_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          // a line that is high again at mid start bit was only a glitch
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[DATA_WIDTH_UART-1:1]};
          if (bit_cnt_q == BIT_W'(DATA_WIDTH_UART - 1)) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d   = '0;
          stop_sample = 1'b1;
          state_d     = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_bad  = stop_sample & ~rx_sync_q;
  assign parity_bad = stop_sample & (par_sync_q[0] != ^shift_q);
  assign byte_good  = stop_sample & ~frame_bad & ~parity_bad;
  assign gap_fire   = (state_q == IDLE) && (byte_idx_q != '0) &&
                      (gap_q == GAP_W'(GAP_LIMIT - 1));

  always_comb begin
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    tmo_d      = 1'b0;
    gap_d      = gap_q;
    perr_d     = (i_clear_err ? 1'b0 : perr_q) | parity_bad;
    ferr_d     = (i_clear_err ? 1'b0 : ferr_q) | frame_bad;

    // gap restarts on every start edge, so a start coinciding with the timeout begins a new word
    if (state_q != IDLE || byte_idx_q == '0 || start_edge || gap_fire) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end

    if (byte_good) begin
      if (byte_idx_q == IDX_W'(BYTES - 1)) begin
        word_d = asm_q;
        word_d[(BYTES-1)*DATA_WIDTH_UART +: DATA_WIDTH_UART] = shift_q;
        valid_d    = 1'b1;
        count_d    = count_q + 16'd1;
        byte_idx_d = '0;
      end else begin
        for (int unsigned b = 0; b < BYTES; b++) begin
          if (byte_idx_q == IDX_W'(b)) begin
            asm_d[b*DATA_WIDTH_UART +: DATA_WIDTH_UART] = shift_q;
          end
        end
        byte_idx_d = byte_idx_q + IDX_W'(1);
      end
    end else if (frame_bad || parity_bad) begin
      byte_idx_d = '0;
    end else if (gap_fire) begin
      byte_idx_d = '0;
      tmo_d      = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      tmo_q      <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_word_count = count_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_debug_word_rx.sv
// Scoreboarded bench for debug_word_rx: stimulus pushes expected words, a monitor pops on o_word_valid.
module tb_debug_word_rx;

  localparam int unsigned CPB = 16;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [0:0]  rx_par;
  logic        clr;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic [15:0] o_word_count;
  logic        o_parity_err;
  logic        o_frame_err;
  logic        o_timeout;

  typedef struct {
    logic [31:0] w;
    logic [15:0] c;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_count;
  int          n_cmp;
  int          n_bad;
  int          n_timeout;

  debug_word_rx #(
    .DATA_WIDTH(32),
    .DATA_WIDTH_UART(8),
    .PARITY_WIDTH_UART(1),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(32)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_rx_data(rx),
    .i_rx_parity(rx_par),
    .i_clear_err(clr),
    .o_word(o_word),
    .o_word_valid(o_word_valid),
    .o_word_count(o_word_count),
    .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  initial begin
    n_timeout = 0;
    forever begin
      @(negedge clk);
      if (o_word_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word", o_word, e.w);
          check("word_count", {16'd0, o_word_count}, {16'd0, e.c});
        end
      end
      if (o_timeout === 1'b1) n_timeout++;
    end
  end

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
    rx_par[0] = par_ok ? ^d : ~^d;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_t e;
    exp_count = exp_count + 16'd1;
    e.w = w;
    e.c = exp_count;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1, 1'b1);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_count = 16'd0;
    rst_n     = 1'b0;
    rx        = 1'b1;
    rx_par    = 1'b0;
    clr       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_word", o_word, 32'h0);
    check("rst_valid", {31'd0, o_word_valid}, 32'd0);
    check("rst_count", {16'd0, o_word_count}, 32'd0);
    check("rst_perr", {31'd0, o_parity_err}, 32'd0);
    check("rst_ferr", {31'd0, o_frame_err}, 32'd0);
    check("rst_timeout", {31'd0, o_timeout}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // basic word
    send_word(32'h1234_5678);
    idle_bits(2);
    check("t1_perr", {31'd0, o_parity_err}, 32'd0);
    check("t1_ferr", {31'd0, o_frame_err}, 32'd0);

    // parity error drops the byte, then a good word; flag is sticky until cleared
    send_frame(8'h01, 1'b0, 1'b1);
    idle_bits(1);
    check("t2_perr_set", {31'd0, o_parity_err}, 32'd1);
    check("t2_ferr", {31'd0, o_frame_err}, 32'd0);
    check("t2_word_held", o_word, 32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    idle_bits(1);
    check("t2_word", o_word, 32'hDEAD_BEEF);
    check("t2_perr_sticky", {31'd0, o_parity_err}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t2_perr_clr", {31'd0, o_parity_err}, 32'd0);

    // timeout discards a 2-byte partial word
    send_frame(8'h33, 1'b1, 1'b1);
    send_frame(8'h44, 1'b1, 1'b1);
    idle_bits(33);
    check("t3_timeouts", n_timeout, 32'd1);
    check("t3_word_held", o_word, 32'hDEAD_BEEF);
    send_word(32'hAAAA_AAAA);
    idle_bits(1);

    // frame error after one good byte resets the byte index
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle_bits(2);
    check("t4_ferr", {31'd0, o_frame_err}, 32'd1);
    check("t4_perr", {31'd0, o_parity_err}, 32'd0);
    check("t4_word_held", o_word, 32'hAAAA_AAAA);
    send_word(32'h0403_0201);
    idle_bits(1);

    // quarter-bit glitch on idle line
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    idle_bits(2);
    check("t5_glitch_word", o_word, 32'h0403_0201);
    check("t5_glitch_count", {16'd0, o_word_count}, 32'd4);
    check("t5_glitch_ferr", {31'd0, o_frame_err}, 32'd1);

    // reset while receiving data bits
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_word", o_word, 32'h0);
    check("t5_rst_count", {16'd0, o_word_count}, 32'd0);
    check("t5_rst_ferr", {31'd0, o_frame_err}, 32'd0);
    check("t5_rst_valid", {31'd0, o_word_valid}, 32'd0);
    exp_count = 16'd0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_word(32'hCAFE_F00D);
    idle_bits(1);

    // count wrap
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    check("t6_preload", {16'd0, o_word_count}, 32'h0000_FFFF);
    exp_count = 16'hFFFF;
    send_word(32'h0BAD_C0DE);
    idle_bits(2);
    check("t6_count_wrap", {16'd0, o_word_count}, 32'd0);

    check("pending_words", exp_q.size(), 32'd0);
    check("total_timeouts", n_timeout, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
